alu_md: RTL and testbench

Parametrised, registered successor to the single-cycle `alu`, adding iterative multiply and divide with a start/ready/valid handshake and a HI/LO result pair. It sits in the EX stage of the pipelined CPU. Single-cycle ops return in one cycle. MULT/DIV ops stall the pipeline through `ready` for WIDTH cycles.

---
 rtl/alu_md.sv | 206 ++++++++++++++++++++
 tb/tb_alu_md.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Registered ALU for the EX stage: single-cycle logic/arithmetic ops plus iterative
// shift-add multiply and restoring divide that produce a HI/LO result pair.
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluCtr,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] aluRes,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             divZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;

    logic             accept;
    logic             multi_op;
    logic             div_op;
    logic             div_by_zero;
    logic             go_busy;
    logic             last_iter;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   next_hi;
    logic [WIDTH-1:0]   next_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    assign ready       = (state == IDLE);
    assign accept      = start && ready;
    assign multi_op    = (aluCtr[3:2] == 2'b10);
    assign div_op      = (aluCtr[3:1] == 3'b101);
    assign div_by_zero = div_op && (input2 == '0);
    assign go_busy     = accept && multi_op && !div_by_zero;
    assign last_iter   = (count == CW'(WIDTH - 1));

    // MIN negates to itself, which read unsigned is exactly its magnitude.
    assign signed_op = aluCtr[0];
    assign a_neg     = signed_op && input1[WIDTH-1];
    assign b_neg     = signed_op && input2[WIDTH-1];
    assign abs_a     = a_neg ? -input1 : input1;
    assign abs_b     = b_neg ? -input2 : input2;

    assign sum = input1 + input2;
    assign dif = input1 - input2;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (aluCtr)
            4'b0000: sc_res = input1 & input2;
            4'b0001: sc_res = input1 | input2;
            4'b0011: sc_res = input1 ^ input2;
            4'b1100: sc_res = ~(input1 | input2);
            4'b0010: begin
                sc_res = sum;
                sc_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            4'b0110: begin
                sc_res = dif;
                sc_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (dif[WIDTH-1] != input1[WIDTH-1]);
            end
            4'b0111: sc_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            default: ;
        endcase
    end

    // acc_hi/acc_lo hold the running product for multiply and remainder/quotient for divide.
    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        trial   = shifted - {1'b0, opb};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                next_hi = trial[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            next_hi = add_sum[WIDTH:1];
            next_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {next_hi, next_lo};
        prod_fix = neg_lo ? -prod : prod;
        if (is_div) begin
            fin_lo = neg_lo ? -next_lo : next_lo;
            fin_hi = neg_hi ? -next_hi : next_hi;
        end else begin
            fin_lo = prod_fix[WIDTH-1:0];
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go_busy) state_next = BUSY;
            BUSY:    if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            aluRes   <= '0;
            hi       <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            divZero  <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE && accept) begin
                if (go_busy) begin
                    count  <= '0;
                    is_div <= div_op;
                    neg_lo <= a_neg ^ b_neg;
                    neg_hi <= a_neg;
                    acc_hi <= '0;
                    acc_lo <= abs_a;
                    opb    <= abs_b;
                end else if (div_by_zero) begin
                    aluRes   <= '1;
                    hi       <= input1;
                    zero     <= 1'b0;
                    overflow <= 1'b0;
                    divZero  <= 1'b1;
                    valid    <= 1'b1;
                end else begin
                    aluRes   <= sc_res;
                    hi       <= '0;
                    zero     <= (sc_res == '0);
                    overflow <= sc_ovf;
                    divZero  <= 1'b0;
                    valid    <= 1'b1;
                end
            end else if (state == BUSY) begin
                acc_hi <= next_hi;
                acc_lo <= next_lo;
                count  <= count + CW'(1);
                if (last_iter) begin
                    aluRes   <= fin_lo;
                    hi       <= fin_hi;
                    zero     <= (fin_lo == '0);
                    overflow <= 1'b0;
                    divZero  <= 1'b0;
                    valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed, table-driven bench for alu_md at WIDTH=32 with hand-computed expectations
// plus sequences for abort-by-reset and back-to-back issue.
module tb_alu_md;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   aluCtr;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic         ready;
    logic         valid;
    logic [W-1:0] aluRes;
    logic [W-1:0] hi;
    logic         zero;
    logic         overflow;
    logic         divZero;

    int checks = 0;
    int errors = 0;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .aluCtr(aluCtr),
        .input1(input1),
        .input2(input2),
        .ready(ready),
        .valid(valid),
        .aluRes(aluRes),
        .hi(hi),
        .zero(zero),
        .overflow(overflow),
        .divZero(divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic       exp_zero;
        logic       exp_ovf;
        logic       exp_dz;
        int         exp_edges;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds start for exactly one rising edge; returns 1ns after that accept edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        aluCtr = op;
        input1 = a;
        input2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accept edge until valid; flags ready going high early.
    task automatic waitValid(output int edges, output logic ready_early);
        edges = 0;
        ready_early = 1'b0;
        while (!valid && edges < 64) begin
            if (ready) ready_early = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic addVec(input string n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] h, input logic z, input logic o,
                          input logic dz, input int e);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.exp_lo = lo; v.exp_hi = h;
        v.exp_zero = z; v.exp_ovf = o; v.exp_dz = dz; v.exp_edges = e;
        vecs.push_back(v);
    endtask

    initial begin
        int   edges;
        logic early;
        logic saw_valid;
        logic saw_ready;

        addVec("and",       4'b0000, 32'd255,        32'd170,        32'd170,        32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("sub_zero",  4'b0110, 32'd1,          32'd1,          32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 0);
        addVec("slt_pos",   4'b0111, 32'd170,        32'd255,        32'd1,          32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("slt_neg",   4'b0111, 32'hFFFFFFFF,   32'd1,          32'd1,          32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("slt_false", 4'b0111, 32'd1,          32'hFFFFFFFF,   32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 0);
        addVec("nor",       4'b1100, 32'd0,          32'd1,          32'hFFFFFFFE,   32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("or",        4'b0001, 32'h0F0,        32'h00F,        32'h0FF,        32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("xor",       4'b0011, 32'hFF,         32'h0F,         32'hF0,         32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("add_ovf",   4'b0010, 32'h7FFFFFFF,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b1, 1'b0, 0);
        addVec("sub_ovf",   4'b0110, 32'h80000000,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 1'b1, 1'b0, 0);
        addVec("and_noovf", 4'b0000, 32'h80000000,   32'h80000000,   32'h80000000,   32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("mult_m3x7", 4'b1001, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFEB,   32'hFFFFFFFF,   1'b0, 1'b0, 1'b0, W);
        addVec("multu_max", 4'b1000, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'hFFFFFFFE,   1'b0, 1'b0, 1'b0, W);
        addVec("mult_6xm4", 4'b1001, 32'd6,          32'hFFFFFFFC,   32'hFFFFFFE8,   32'hFFFFFFFF,   1'b0, 1'b0, 1'b0, W);
        addVec("div_m7_2",  4'b1011, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 1'b0, W);
        addVec("divu_100_7",4'b1010, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 1'b0, W);
        addVec("div_min_m1",4'b1011, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b0, 1'b0, W);
        addVec("divu_by0",  4'b1010, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b0, 1'b0, 1'b1, 0);
        addVec("add_clrdz", 4'b0010, 32'd2,          32'd3,          32'd5,          32'd0,          1'b0, 1'b0, 1'b0, 0);
        addVec("div_7_m2",  4'b1011, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 1'b0, W);

        reset  = 1'b1;
        start  = 1'b0;
        aluCtr = 4'b0000;
        input1 = '0;
        input2 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_aluRes", aluRes, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_flags", {zero, overflow, divZero, valid}, 0);
        checkOutput("rst_ready", ready, 1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitValid(edges, early);
            checkOutput({vecs[i].name, "_latency"}, edges, vecs[i].exp_edges);
            checkOutput({vecs[i].name, "_aluRes"}, aluRes, vecs[i].exp_lo);
            checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            checkOutput({vecs[i].name, "_zero"}, zero, vecs[i].exp_zero);
            checkOutput({vecs[i].name, "_overflow"}, overflow, vecs[i].exp_ovf);
            checkOutput({vecs[i].name, "_divZero"}, divZero, vecs[i].exp_dz);
            checkOutput({vecs[i].name, "_ready_in_valid"}, ready, 1);
            if (vecs[i].exp_edges != 0)
                checkOutput({vecs[i].name, "_ready_low"}, early, 0);
        end

        // Abort: MULTU accepted, AND pulsed at cycle 5 while busy, reset at cycle 10.
        applyStimulus(4'b1000, 32'd1000, 32'd1000);
        saw_valid = 1'b0;
        saw_ready = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 5) begin
                start  = 1'b1;
                aluCtr = 4'b0000;
                input1 = 32'hFF;
                input2 = 32'hFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (valid) saw_valid = 1'b1;
            if (ready) saw_ready = 1'b1;
        end
        checkOutput("busy_ignores_start_valid", saw_valid, 0);
        checkOutput("busy_ignores_start_ready", saw_ready, 0);
        checkOutput("busy_holds_aluRes", aluRes, 32'hFFFFFFFD);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_aluRes", aluRes, 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_flags", {zero, overflow, divZero, valid}, 0);
        checkOutput("abort_ready", ready, 1);
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (valid) saw_valid = 1'b1;
        end
        checkOutput("abort_no_valid", saw_valid, 0);

        applyStimulus(4'b1000, 32'd3, 32'd5);
        waitValid(edges, early);
        checkOutput("after_abort_latency", edges, W);
        checkOutput("after_abort_result", {hi, aluRes}, 64'd15);

        // Back-to-back: issue ADD during the valid cycle of a MULTU.
        applyStimulus(4'b1000, 32'd2, 32'd3);
        waitValid(edges, early);
        checkOutput("b2b_mult_latency", edges, W);
        checkOutput("b2b_mult_result", {hi, aluRes}, 64'd6);
        applyStimulus(4'b0010, 32'd1, 32'd2);
        checkOutput("b2b_add_valid", valid, 1);
        checkOutput("b2b_add_result", aluRes, 32'd3);
        @(posedge clk);
        #1;
        checkOutput("valid_single_pulse", valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
